// File: rtl/sound_latch_fifo_if.sv
// Bus bundle between the 68K/Z80 side and the sound command latch.
// master: the CPU side that drives strobes and data.
// slave: the latch itself.
interface sound_latch_fifo_if;
    logic        m68k_latch_cs;
    logic        m68k_rw_n;
    logic        m68k_lds_n;
    logic [15:0] m68k_din;
    logic        z80_latch_cs;
    logic        z80_rd_n;
    logic [7:0]  latch_dout;
    logic        z80_nmi_n;
    logic        pending;
    logic        overrun;

    modport master (
        output m68k_latch_cs, m68k_rw_n, m68k_lds_n, m68k_din,
        output z80_latch_cs, z80_rd_n,
        input  latch_dout, z80_nmi_n, pending, overrun
    );

    modport slave (
        input  m68k_latch_cs, m68k_rw_n, m68k_lds_n, m68k_din,
        input  z80_latch_cs, z80_rd_n,
        output latch_dout, z80_nmi_n, pending, overrun
    );
endinterface

// File: rtl/sound_latch_fifo.sv
// Sound command latch from the 68000 to the Z80.
// Command bytes are buffered in a small circular FIFO. The head byte is
// presented to the Z80, and each buffered command gets one NMI pulse.
// A write into a full buffer replaces the newest entry and sets a sticky
// overrun flag.
module sound_latch_fifo #(
    parameter int DEPTH     = 1,
    parameter int NMI_WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    sound_latch_fifo_if.slave  bus
);
    localparam int              PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              CW       = $clog2(DEPTH + 1);
    localparam logic [PW-1:0]   LAST_IDX = PW'(DEPTH - 1);
    localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);
    localparam logic [7:0]      TLOAD    = 8'(NMI_WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_PULSE, S_GAP} state_t;

    logic [7:0]    r_mem [2**PW];
    logic [PW-1:0] r_wr_ptr, r_rd_ptr;
    logic [CW-1:0] r_count, r_owed;
    logic [7:0]    r_last_byte;
    logic          r_overrun;
    logic          r_ws_d, r_rs_d;
    state_t        r_state;
    logic [7:0]    r_timer;
    logic          r_nmi_n;

    logic          w_ws, w_rs, w_push, w_pop;
    logic [CW-1:0] w_count_after_pop;
    logic          w_full_after_pop, w_push_ins, w_push_ovw;
    logic [PW-1:0] w_newest, w_wr_addr;
    logic [CW-1:0] w_owed_next;
    state_t        w_state_next;
    logic [7:0]    w_timer_next;
    logic          w_fire;
    logic          w_unused_din_hi;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_IDX) ? '0 : p + PW'(1);
    endfunction

    assign w_ws = bus.m68k_latch_cs & ~bus.m68k_rw_n & ~bus.m68k_lds_n;
    assign w_rs = bus.z80_latch_cs & ~bus.z80_rd_n;

    // Push on the leading edge of the write; pop on the trailing edge of the read
    // so the Z80 sees stable data for the whole read cycle.
    assign w_push = w_ws & ~r_ws_d;
    assign w_pop  = ~w_rs & r_rs_d & (r_count != '0);

    // The pop is applied before the push, so a simultaneous pop frees a slot.
    assign w_count_after_pop = r_count - CW'(w_pop);
    assign w_full_after_pop  = (w_count_after_pop == FULL_CNT);
    assign w_push_ins        = w_push & ~w_full_after_pop;
    assign w_push_ovw        = w_push & w_full_after_pop;
    assign w_newest          = (r_wr_ptr == '0) ? LAST_IDX : r_wr_ptr - PW'(1);
    assign w_wr_addr         = w_push_ovw ? w_newest : r_wr_ptr;
    assign w_unused_din_hi   = ^bus.m68k_din[15:8];

    // Strobe edge detectors.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ws_d <= 1'b0;
            r_rs_d <= 1'b0;
        end else begin
            r_ws_d <= w_ws;
            r_rs_d <= w_rs;
        end
    end

    // Command storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[w_wr_addr] <= bus.m68k_din[7:0];
    end

    // Pointers, occupancy, last-read byte and sticky overrun.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_last_byte <= 8'h00;
            r_overrun   <= 1'b0;
        end else begin
            if (w_pop) begin
                r_last_byte <= r_mem[r_rd_ptr];
                r_rd_ptr    <= ptr_inc(r_rd_ptr);
            end
            if (w_push_ins) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_push_ovw) r_overrun <= 1'b1;
            r_count <= w_count_after_pop + CW'(w_push_ins);
        end
    end

    // Owed NMIs: a new command adds one, starting a pulse consumes one.
    always_comb begin
        w_owed_next = r_owed;
        if (w_push_ins && !w_fire) begin
            if (r_owed != FULL_CNT) w_owed_next = r_owed + CW'(1);
        end else if (!w_push_ins && w_fire) begin
            w_owed_next = r_owed - CW'(1);
        end
    end

    // Owed counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_owed <= '0;
        else          r_owed <= w_owed_next;
    end

    // NMI sequencer next state: low pulse, then an equally long high gap.
    always_comb begin
        w_state_next = r_state;
        w_timer_next = r_timer;
        w_fire       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_owed != '0) begin
                    w_state_next = S_PULSE;
                    w_timer_next = TLOAD;
                    w_fire       = 1'b1;
                end
            end
            S_PULSE: begin
                if (r_timer == 8'd0) begin
                    w_state_next = S_GAP;
                    w_timer_next = TLOAD;
                end else begin
                    w_timer_next = r_timer - 8'd1;
                end
            end
            S_GAP: begin
                if (r_timer == 8'd0) w_state_next = S_IDLE;
                else                 w_timer_next = r_timer - 8'd1;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // NMI sequencer registers; NMI output is registered from the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_timer <= 8'd0;
            r_nmi_n <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_timer <= w_timer_next;
            r_nmi_n <= (w_state_next != S_PULSE);
        end
    end

    assign bus.latch_dout = (r_count != '0) ? r_mem[r_rd_ptr] : r_last_byte;
    assign bus.pending    = (r_count != '0);
    assign bus.overrun    = r_overrun;
    assign bus.z80_nmi_n  = r_nmi_n;
endmodule
